bip_control: RTL
================

Name: bip_control

Overview:
- Instruction fetch/decode controller for the accumulator CPU.
- Sits directly upstream of the program memory: drives its address and consumes the 16-bit instruction word it returns.
- Instruction word is a 5-bit opcode in the MSBs and an operand in the remaining bits.
- Produces registered control strobes for the accumulator/ALU/data-RAM datapath.
- Counts the clock cycles spent executing a program, from Start until HLT.

Parameters:
- ADDR_BUS, 11, program counter / program memory address width
- DATA_SIZE, 16, instruction width; opcode = [DATA_SIZE-1:DATA_SIZE-5]
- OPERAND_W, DATA_SIZE-5, operand field width
- CNT_W, 32, cycle counter width

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  begin execution from address 0 (level, sampled on Clk)
- Prog_Addr  out  ADDR_BUS  program counter to program memory
- Prog_Data  in  DATA_SIZE  instruction from program memory (combinational read of Prog_Addr)
- Operand  out  OPERAND_W  operand field of current instruction (data-RAM address or immediate)
- SelA  out  2  accumulator source: 00 data RAM, 01 immediate, 10 ALU result
- SelB  out  1  ALU B operand: 0 data RAM, 1 immediate
- Op  out  1  ALU op: 0 add, 1 subtract
- WrAcc  out  1  accumulator write strobe
- WrRam  out  1  data-RAM write strobe
- RdRam  out  1  data-RAM read strobe
- Halted  out  1  high while in HALT
- Cycle_Count  out  CNT_W  execution cycles of the current or last run

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE, PC=0, Operand=0, all strobes 0, SelA=00, SelB=0, Op=0, Halted=0, Cycle_Count=0.
- Opcodes: HLT=0, STO=1, LD=2, LDI=3, ADD=4, ADDI=5, SUB=6, SUBI=7. Codes 8..31 are NOP: one EXEC cycle with no strobes.
- States and transitions:
  - IDLE: Start=1 -> FETCH.
  - FETCH: Prog_Addr=PC. On the edge, decode Prog_Data. Opcode HLT -> HALT with PC unchanged. Otherwise Operand<=Prog_Data[OPERAND_W-1:0], strobe registers loaded from decode, PC<=PC+1, -> EXEC.
  - EXEC: strobes high for exactly this one cycle, then cleared on the edge -> FETCH.
  - HALT: Halted=1, PC and Cycle_Count frozen. Start=1 -> PC=0, Cycle_Count=0, Halted=0, -> FETCH.
- Start is ignored in FETCH and EXEC.
- Decode table, asserted during EXEC only:
  - STO: WrRam.
  - LD: RdRam, WrAcc, SelA=00.
  - LDI: WrAcc, SelA=01.
  - ADD: RdRam, WrAcc, SelA=10, SelB=0, Op=0.
  - ADDI: WrAcc, SelA=10, SelB=1, Op=0.
  - SUB: RdRam, WrAcc, SelA=10, SelB=0, Op=1.
  - SUBI: WrAcc, SelA=10, SelB=1, Op=1.
- SelA, SelB, Op: return to 00/0/0 outside EXEC.
- Operand: held until the next non-HLT fetch.
- Latency: each non-HLT instruction takes 2 cycles. HLT takes 1 cycle (FETCH only).
- Cycle_Count: +1 on every edge taken in FETCH or EXEC. Saturates at 2^CNT_W-1. Never wraps.
- PC wrap: PC=2^ADDR_BUS-1 increments to 0, with no flag.
- Reset mid-instruction (any state): immediate return to reset values. Strobes drop asynchronously, so no partial RAM write survives past reset assertion.

Decomposition:
- Shared package bip_pkg holds:
  - opcode localparams,
  - SelA encodings (SEL_RAM, SEL_IMM, SEL_ALU),
  - state encoding (IDLE, FETCH, EXEC, HALT),
  - opcode field width 5.
- The program memory and datapath use the same opcode constants.
- One combinational sub-module, bip_decoder: opcode in; SelA, SelB, Op, WrAcc, WrRam, RdRam, is_halt out.
- The FSM, PC and counter stay in bip_control.

Test Plan:
- Reset: hold Reset=0 with random Prog_Data and Start=1 -> Prog_Addr=0, all strobes 0, Halted=0, Cycle_Count=0, state stays IDLE.
- Program run: memory holds LDI 16, STO 1, LD 1, ADDI 255, STO 2, LD 16, HLT; pulse Start -> required response:
  - EXEC strobes in order: WrAcc/SelA=01/Operand=16; WrRam/Operand=1; RdRam+WrAcc/SelA=00; WrAcc/SelA=10/SelB=1/Op=0/Operand=255; WrRam/Operand=2; RdRam+WrAcc/Operand=16.
  - Then Halted=1, Prog_Addr=6, Cycle_Count=13, both held for 20 further cycles.
- Restart: Start=1 while Halted -> Cycle_Count=0 and Prog_Addr=0 on the next edge, and the program reruns to Cycle_Count=13.
- NOP/SUB: opcode 9 at address 0, SUBI 3 at address 1 -> first EXEC has no strobes; second EXEC has WrAcc, SelA=10, SelB=1, Op=1, Operand=3.
- Wrap: ADDR_BUS=3, memory all ADDI 1 -> Prog_Addr goes 7 -> 0 after the 8th fetch, execution continues; Start pulses mid-run have no effect.
- Mid-run reset: assert Reset during the EXEC of STO -> WrRam falls in the same cycle without waiting for Clk; after release, IDLE with Prog_Addr=0, Cycle_Count=0.

Source files
------------

// File: rtl/bip_pkg.sv
// rtl/bip_pkg.sv - shared opcode, select and state encodings for the accumulator CPU
package bip_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_HLT  = 5'd0;
    localparam logic [OPC_W-1:0] OP_STO  = 5'd1;
    localparam logic [OPC_W-1:0] OP_LD   = 5'd2;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'd3;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'd4;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'd5;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'd6;
    localparam logic [OPC_W-1:0] OP_SUBI = 5'd7;

    localparam logic [1:0] SEL_RAM = 2'b00;
    localparam logic [1:0] SEL_IMM = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/bip_decoder.sv
// rtl/bip_decoder.sv - combinational opcode to datapath-control decoder
// Ports:
//   opcode  in   5-bit instruction opcode
//   SelA    out  accumulator source (SEL_RAM / SEL_IMM / SEL_ALU)
//   SelB    out  ALU B operand: 0 data RAM, 1 immediate
//   Op      out  ALU op: 0 add, 1 subtract
//   WrAcc   out  accumulator write
//   WrRam   out  data-RAM write
//   RdRam   out  data-RAM read
//   is_halt out  opcode is HLT
module bip_decoder
    import bip_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic [1:0]       SelA,
    output logic             SelB,
    output logic             Op,
    output logic             WrAcc,
    output logic             WrRam,
    output logic             RdRam,
    output logic             is_halt
);

    always_comb begin
        SelA    = SEL_RAM;
        SelB    = 1'b0;
        Op      = 1'b0;
        WrAcc   = 1'b0;
        WrRam   = 1'b0;
        RdRam   = 1'b0;
        is_halt = 1'b0;
        case (opcode)
            OP_HLT:  is_halt = 1'b1;
            OP_STO:  WrRam = 1'b1;
            OP_LD: begin
                RdRam = 1'b1;
                WrAcc = 1'b1;
            end
            OP_LDI: begin
                WrAcc = 1'b1;
                SelA  = SEL_IMM;
            end
            OP_ADD: begin
                RdRam = 1'b1;
                WrAcc = 1'b1;
                SelA  = SEL_ALU;
            end
            OP_ADDI: begin
                WrAcc = 1'b1;
                SelA  = SEL_ALU;
                SelB  = 1'b1;
            end
            OP_SUB: begin
                RdRam = 1'b1;
                WrAcc = 1'b1;
                SelA  = SEL_ALU;
                Op    = 1'b1;
            end
            OP_SUBI: begin
                WrAcc = 1'b1;
                SelA  = SEL_ALU;
                SelB  = 1'b1;
                Op    = 1'b1;
            end
            default: ;  // codes 8..31 execute as NOP
        endcase
    end

endmodule

// File: rtl/bip_control.sv
// rtl/bip_control.sv - instruction fetch/decode controller with run-cycle counter
// Ports:
//   Clk, Reset      clock (rising edge), asynchronous active-low reset
//   Start           begin execution from address 0 (honoured in IDLE and HALT)
//   Prog_Addr       program counter to program memory
//   Prog_Data       instruction word returned for Prog_Addr
//   Operand         operand field of the current instruction
//   SelA/SelB/Op    datapath selects, valid during EXEC only
//   WrAcc/WrRam/RdRam  one-cycle EXEC strobes
//   Halted          high while halted
//   Cycle_Count     saturating count of FETCH/EXEC cycles in this run
module bip_control
    import bip_pkg::*;
#(
    parameter int ADDR_BUS  = 11,
    parameter int DATA_SIZE = 16,
    parameter int OPERAND_W = DATA_SIZE - 5,
    parameter int CNT_W     = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    output logic [ADDR_BUS-1:0]  Prog_Addr,
    input  logic [DATA_SIZE-1:0] Prog_Data,
    output logic [OPERAND_W-1:0] Operand,
    output logic [1:0]           SelA,
    output logic                 SelB,
    output logic                 Op,
    output logic                 WrAcc,
    output logic                 WrRam,
    output logic                 RdRam,
    output logic                 Halted,
    output logic [CNT_W-1:0]     Cycle_Count
);

    state_t state, state_next;
    logic [ADDR_BUS-1:0] pc;

    logic [1:0] dec_sel_a;
    logic       dec_sel_b, dec_op, dec_wr_acc, dec_wr_ram, dec_rd_ram, dec_is_halt;
    logic       load_instr, restart, counting;

    bip_decoder u_decoder (
        .opcode  (Prog_Data[DATA_SIZE-1 -: OPC_W]),
        .SelA    (dec_sel_a),
        .SelB    (dec_sel_b),
        .Op      (dec_op),
        .WrAcc   (dec_wr_acc),
        .WrRam   (dec_wr_ram),
        .RdRam   (dec_rd_ram),
        .is_halt (dec_is_halt)
    );

    always_comb begin
        state_next = state;
        load_instr = 1'b0;
        restart    = 1'b0;
        counting   = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_next = FETCH;
                    restart    = 1'b1;
                end
            end
            FETCH: begin
                counting = 1'b1;
                if (dec_is_halt) begin
                    state_next = HALT;
                end else begin
                    state_next = EXEC;
                    load_instr = 1'b1;
                end
            end
            EXEC: begin
                counting   = 1'b1;
                state_next = FETCH;
            end
            HALT: begin
                if (Start) begin
                    state_next = FETCH;
                    restart    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    // Strobes are loaded only on the FETCH edge and cleared on every other
    // edge, so they are high for exactly the EXEC cycle. The async reset
    // drops them immediately, cutting off any RAM write in progress.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc          <= '0;
            Operand     <= '0;
            SelA        <= SEL_RAM;
            SelB        <= 1'b0;
            Op          <= 1'b0;
            WrAcc       <= 1'b0;
            WrRam       <= 1'b0;
            RdRam       <= 1'b0;
            Cycle_Count <= '0;
        end else begin
            SelA  <= SEL_RAM;
            SelB  <= 1'b0;
            Op    <= 1'b0;
            WrAcc <= 1'b0;
            WrRam <= 1'b0;
            RdRam <= 1'b0;
            if (load_instr) begin
                Operand <= Prog_Data[OPERAND_W-1:0];
                SelA    <= dec_sel_a;
                SelB    <= dec_sel_b;
                Op      <= dec_op;
                WrAcc   <= dec_wr_acc;
                WrRam   <= dec_wr_ram;
                RdRam   <= dec_rd_ram;
                pc      <= pc + 1'b1;  // wraps silently at the top of memory
            end
            if (restart) begin
                pc          <= '0;
                Cycle_Count <= '0;
            end else if (counting && (Cycle_Count != {CNT_W{1'b1}})) begin
                Cycle_Count <= Cycle_Count + 1'b1;
            end
        end
    end

    assign Prog_Addr = pc;
    assign Halted    = (state == HALT);

endmodule
